// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// and holds the result under a valid/ready handshake until it is consumed.
//
// state | meaning
// IDLE  | waiting for start; last result held on diff/bout/zero
// RUN   | one full-subtractor step per cycle, WIDTH cycles total
// HOLD  | result valid, waiting for out_ready
module serial_sub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_sh, b_sh, res_sh, diff_r;
    logic             br, bout_r;
    logic [CW-1:0]    cnt;
    logic             ai, bi, d_bit, br_next;
    logic [WIDTH-1:0] res_next;

    assign ai       = a_sh[0];
    assign bi       = b_sh[0];
    assign d_bit    = ai ^ bi ^ br;
    assign br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    assign res_next = {d_bit, res_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == LAST_BIT) state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The output registers are separate from the shift register so the
    // previous result stays visible while a new one is being computed.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_r <= '0;
            bout_r <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a;
                        b_sh   <= b;
                        br     <= bin;
                        res_sh <= '0;
                        cnt    <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    br     <= br_next;
                    res_sh <= res_next;
                    if (cnt == LAST_BIT) begin
                        diff_r <= res_next;
                        bout_r <= br_next;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == HOLD);
    assign diff      = diff_r;
    assign bout      = bout_r;
    assign zero      = (diff_r == '0);

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: table of hand-computed subtractions plus
// sequences for start-held, back-pressure and mid-run reset behaviour.
module tb_serial_sub;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, bin, out_ready;
    logic [W-1:0] a, b;
    logic         busy, out_valid, bout, zero;
    logic [W-1:0] diff;

    int tests_run = 0;
    int tests_failed = 0;

    serial_sub #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] diff;
        logic         bout;
        logic         zero;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full transaction with out_ready already high: checks latency, result and
    // the handshake back to IDLE.
    task automatic run_op(input string name, input vec_t v);
        a = v.a; b = v.b; bin = v.bin;
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = ~v.a; b = ~v.b; bin = ~v.bin;
        check({name, " busy"}, busy, 1);
        repeat (W - 1) tick();
        check({name, " early_valid"}, out_valid, 0);
        tick();
        check({name, " valid"}, out_valid, 1);
        check({name, " diff"}, diff, v.diff);
        check({name, " bout"}, bout, v.bout);
        check({name, " zero"}, zero, v.zero);
        tick();
        check({name, " idle_busy"}, busy, 0);
        check({name, " idle_valid"}, out_valid, 0);
        check({name, " idle_diff"}, diff, v.diff);
        out_ready = 1'b0;
    endtask

    initial begin
        logic         stable;
        logic         saw_valid;
        logic [W-1:0] hold_diff;
        logic         hold_bout;

        vecs[0] = '{8'd10,  8'd3,   1'b0, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'd3,   8'd10,  1'b0, 8'hF9, 1'b1, 1'b0};
        vecs[2] = '{8'd5,   8'd5,   1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'd0,   8'd0,   1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'hFF,  8'h01,  1'b0, 8'hFE, 1'b0, 1'b0};
        vecs[5] = '{8'h80,  8'h01,  1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[6] = '{8'h00,  8'hFF,  1'b0, 8'h01, 1'b1, 1'b0};
        vecs[7] = '{8'hFF,  8'hFF,  1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h01,  8'h00,  1'b1, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{8'hA5,  8'h5A,  1'b1, 8'h4A, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b1; out_ready = 1'b0;
        a = 8'h12; b = 8'h34; bin = 1'b0;
        tick();
        tick();
        check("reset busy", busy, 0);
        check("reset valid", out_valid, 0);
        check("reset diff", diff, 0);
        check("reset bout", bout, 0);
        check("reset zero", zero, 1);
        rst = 1'b0; start = 1'b0;
        tick();

        for (int i = 0; i < 10; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
            tick();
        end

        // start held high with operands churning: only the accepted operands count
        a = 8'h40; b = 8'h15; bin = 1'b0; start = 1'b1; out_ready = 1'b0;
        tick();
        for (int i = 0; i < W; i++) begin
            a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
            tick();
        end
        check("held valid", out_valid, 1);
        check("held diff", diff, 8'h2B);
        check("held bout", bout, 0);
        repeat (3) begin
            a = W'($urandom); b = W'($urandom);
            tick();
        end
        check("held hold_diff", diff, 8'h2B);
        a = 8'h09; b = 8'h0A; bin = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("held no_same_edge_start", busy, 0);
        check("held handshake_valid", out_valid, 0);
        tick();
        start = 1'b0;
        check("held reaccept busy", busy, 1);
        repeat (W) tick();
        check("held second valid", out_valid, 1);
        check("held second diff", diff, 8'hFF);
        check("held second bout", bout, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("held second idle", busy, 0);
        tick();

        // back-pressure for 20 cycles
        a = 8'h64; b = 8'h20; bin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (W) tick();
        check("bp valid", out_valid, 1);
        check("bp diff", diff, 8'h43);
        hold_diff = diff; hold_bout = bout;
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid !== 1'b1 || diff !== hold_diff || bout !== hold_bout || zero !== 1'b0)
                stable = 1'b0;
        end
        check("bp stable", stable, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp release busy", busy, 0);
        check("bp release valid", out_valid, 0);
        check("bp retained diff", diff, 8'h43);
        tick();

        // reset at bit 4 of RUN, with start high on the reset edge
        a = 8'h55; b = 8'h11; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("midrun rst busy", busy, 0);
        check("midrun rst valid", out_valid, 0);
        check("midrun rst diff", diff, 0);
        check("midrun rst zero", zero, 1);
        saw_valid = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) saw_valid = 1'b1;
        end
        check("midrun no pulse", saw_valid, 0);
        run_op("after_rst", vecs[4]);
        tick();

        // reset while in HOLD
        a = 8'h30; b = 8'h10; bin = 1'b0; start = 1'b1; out_ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (W) tick();
        check("hold pre_rst valid", out_valid, 1);
        rst = 1'b1; out_ready = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        check("hold rst valid", out_valid, 0);
        check("hold rst diff", diff, 0);
        run_op("after_hold_rst", vecs[1]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
